rotary_ctrl: RTL and testbench
==============================

# rotary_ctrl

Sequencing controller for the quadrature-encoder front end. It consumes the single-cycle rising-edge pulse of filtered channel A and the filtered level of channel B, and decodes the rotation direction. It applies a lockout window after each accepted edge to reject contact bounce, and maintains a position counter. Each position change is published over a valid/ready event interface to downstream display/control logic.

## Interface
- `CNT_W`, default 8: position counter width.
- `LOCK_CYC`, default 50000: lockout length in clk cycles after an accepted edge. Legal range is ≥1.
- `POS_INIT`, default 0: position value loaded at reset and on `clr`.
- `clk` input, 1 bit: single system clock; all logic on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset (0 = reset).
- `enc_a_pos` input, 1 bit: one-cycle pulse on each filtered channel-A rising edge.
- `enc_b_lvl` input, 1 bit: filtered channel-B level.
- `clr` input, 1 bit: synchronous clear of the position and the overflow flag.
- `pos` output, `CNT_W` bits: current position.
- `dir` output, 1 bit: direction of the last accepted step (1 = increment, 0 = decrement).
- `evt_valid` output, 1 bit: a position-change event is pending.
- `evt_ready` input, 1 bit: the consumer accepts the event.
- `evt_ovf` output, 1 bit: sticky flag; set when an unconsumed event is overwritten.
- `busy` output, 1 bit: high while in LOCK.

## Operation
- FSM states: IDLE and LOCK. Reset enters IDLE.
- **IDLE:**
  - `enc_a_pos`=1 is an accepted edge.
  - If `enc_b_lvl`=0: `pos`+1 and `dir`=1. If `enc_b_lvl`=1: `pos`-1 and `dir`=0.
  - The FSM moves to LOCK and loads the lockout counter with `LOCK_CYC`-1.
- **LOCK:**
  - `enc_a_pos` is ignored; no position change and no event.
  - The counter decrements each cycle. The FSM returns to IDLE in the cycle after the counter reads 0.
- **Event handshake:**
  - An accepted edge sets `evt_valid`.
  - A transfer occurs when `evt_valid`=1 and `evt_ready`=1 in the same cycle. `evt_valid` then clears in the next cycle.
  - An edge accepted in the same cycle as a transfer keeps `evt_valid` high, now reporting the new `pos`. `evt_ovf` is not set in this case.
  - An edge accepted while `evt_valid`=1 and `evt_ready`=0 updates `pos` and sets `evt_ovf`. `evt_valid` stays 1.
  - `evt_ready` with `evt_valid`=0 has no effect.
- **`clr`:**
  - Loads `pos`=`POS_INIT`, clears `evt_ovf` and `evt_valid`, and forces IDLE.
  - `clr` has priority over a simultaneous edge; that edge is dropped.
- **Arithmetic:** `pos` is `CNT_W`-bit unsigned. Boundary behaviour at 0 and 2^`CNT_W`-1 is set by the configuration macro.
- **Reset values:** `pos`=`POS_INIT`, `dir`=0, `evt_valid`=0, `evt_ovf`=0, `busy`=0. Reset asserted mid-LOCK returns to IDLE immediately and asynchronously.

## Timing
- Edge pulse accepted in cycle t:
  - `pos`, `dir` and `evt_valid` update at t+1.
  - `busy`=1 from t+1 through t+`LOCK_CYC`.
  - IDLE again at t+`LOCK_CYC`+1, so the earliest next accepted edge is in that cycle.
- `evt_valid` drops one cycle after the transfer cycle. A transfer is a registered handshake, not combinational.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `ROTARY_WRAP_EN` defined: `pos` wraps modulo 2^`CNT_W`, so 2^`CNT_W`-1 +1 → 0 and 0 -1 → 2^`CNT_W`-1.
- `ROTARY_WRAP_EN` undefined: `pos` saturates at 0 and 2^`CNT_W`-1.
  - A step against a limit still counts as accepted: it updates `dir`, raises `evt_valid` and starts LOCK.
  - `pos` itself is unchanged.

## Structure
- Package `rotary_pkg`:
  - `rotary_state_t` enum {IDLE, LOCK}.
  - Constants `DIR_INC`=1'b1 and `DIR_DEC`=1'b0.
- Sub-module `lockout_timer`:
  - Parameterized down-counter with `start` input and `busy`/`done` outputs.
  - Width is `$clog2(LOCK_CYC)`, minimum 1.
  - Uses the same `clk`/`rst`.

## Test plan
All scenarios use `CNT_W`=4, `LOCK_CYC`=4, `POS_INIT`=0.
- **Basic step:** `enc_a_pos` pulse with `enc_b_lvl`=0 at t → at t+1 `pos`=1, `dir`=1, `evt_valid`=1, `busy`=1; `busy` falls at t+5.
- **Lockout:** pulses at t, t+2 and t+4, all with `enc_b_lvl`=1 → `pos`=15 (wrap build) or 0 (saturate build) after t; the pulses at t+2 and t+4 are ignored.
- **Handshake and overflow:**
  - Edge at t with `evt_ready`=0, then a second edge at t+5 → `evt_ovf`=1 at t+6 and `pos`=2.
  - `evt_ready`=1 at t+7 → `evt_valid`=0 at t+8.
  - `clr` → `evt_ovf`=0.
- **Boundary:**
  - From `pos`=15, an increment edge → 0 (wrap build) or 15 with `evt_valid`=1 (saturate build).
  - From `pos`=0, a decrement edge → 15 or 0 respectively.
- **Priority:** `clr` and `enc_a_pos` in the same cycle → `pos`=0, `evt_valid`=0, `busy`=0.
- **Reset mid-LOCK:** `rst`=0 at t+2 after an edge → `busy`, `evt_valid` and `pos` return to reset values immediately; an edge right after release is accepted.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared types and constants for the quadrature-encoder sequencing controller.
package rotary_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } rotary_state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // Lockout counter width; a one-cycle lockout still needs a 1-bit counter.
  function automatic int lock_cnt_w(input int lock_cyc);
    return (lock_cyc < 2) ? 1 : $clog2(lock_cyc);
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counting bounce-lockout timer: start loads LOCK_CYC-1, done flags the
// last lockout cycle, abort cancels a running lockout.
module lockout_timer
  import rotary_pkg::*;
#(
  parameter int LOCK_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done
);

  localparam int            W    = lock_cnt_w(LOCK_CYC);
  localparam logic [W-1:0]  LOAD = W'(LOCK_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= LOAD;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - W'(1);
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/rotary_ctrl.sv
// Quadrature-encoder step decoder with bounce lockout and a valid/ready event port.
// ROTARY_WRAP_EN defined: position wraps; undefined: position saturates.
//
// state | meaning
// IDLE  | waiting for a channel-A edge; the next edge is accepted
// LOCK  | bounce lockout running; channel-A edges are ignored
module rotary_ctrl
  import rotary_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_CYC = 50000,
  parameter int POS_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a_pos,
  input  logic             enc_b_lvl,
  input  logic             clr,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] POS_RST = CNT_W'(POS_INIT);
  localparam logic [CNT_W-1:0] POS_MAX = '1;

  rotary_state_t    state;
  logic             accept;
  logic             tmr_done;
  logic [CNT_W-1:0] pos_inc;
  logic [CNT_W-1:0] pos_dec;

  assign accept = (state == IDLE) && enc_a_pos && !clr;

`ifdef ROTARY_WRAP_EN
  assign pos_inc = pos + 1'b1;
  assign pos_dec = pos - 1'b1;
`else
  // A step against a limit is still an accepted step; only pos holds.
  assign pos_inc = (pos == POS_MAX) ? pos : pos + 1'b1;
  assign pos_dec = (pos == '0)      ? pos : pos - 1'b1;
`endif

  lockout_timer #(
    .LOCK_CYC (LOCK_CYC)
  ) u_lockout_timer (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .abort (clr),
    .busy  (busy),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pos       <= POS_RST;
      dir       <= DIR_DEC;
      evt_valid <= 1'b0;
      evt_ovf   <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      pos       <= POS_RST;
      evt_valid <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_a_pos) begin
            state <= LOCK;
            if (enc_b_lvl) begin
              pos <= pos_dec;
              dir <= DIR_DEC;
            end else begin
              pos <= pos_inc;
              dir <= DIR_INC;
            end
          end
        end
        LOCK: begin
          if (tmr_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new edge overrides a same-cycle transfer; it only overflows if the old event was never taken.
      if (accept) begin
        evt_valid <= 1'b1;
        if (evt_valid && !evt_ready) evt_ovf <= 1'b1;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotary_ctrl.sv
// Scoreboard bench for rotary_ctrl (CNT_W=4, LOCK_CYC=4, POS_INIT=0).
module tb_rotary_ctrl;

  localparam int CNT_W    = 4;
  localparam int LOCK_CYC = 4;

`ifdef ROTARY_WRAP_EN
  localparam logic [3:0] P_DEC0  = 4'd15;
  localparam logic [3:0] P_INC15 = 4'd0;
`else
  localparam logic [3:0] P_DEC0  = 4'd0;
  localparam logic [3:0] P_INC15 = 4'd15;
`endif

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] pos;
    logic       dir;
    logic       chk_dir;
    logic       v;
    logic       ovf;
    logic       busy;
  } snap_t;

  typedef struct {
    logic [3:0] pos;
    logic       dir;
    logic       ovf;
  } evt_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             enc_a_pos;
  logic             enc_b_lvl;
  logic             clr;
  logic [CNT_W-1:0] pos;
  logic             dir;
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_ovf;
  logic             busy;

  snap_t snap_q[$];
  evt_t  ev_q[$];
  snap_t s;
  evt_t  e;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  bit    done = 1'b0;

  rotary_ctrl #(
    .CNT_W    (CNT_W),
    .LOCK_CYC (LOCK_CYC),
    .POS_INIT (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enc_a_pos (enc_a_pos),
    .enc_b_lvl (enc_b_lvl),
    .clr       (clr),
    .pos       (pos),
    .dir       (dir),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ovf   (evt_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_snap(input int c, input string n, input logic [3:0] p, input logic d,
                          input logic cd, input logic v, input logic o, input logic b);
    snap_t x;
    x.cyc = c; x.name = n; x.pos = p; x.dir = d; x.chk_dir = cd;
    x.v = v; x.ovf = o; x.busy = b;
    snap_q.push_back(x);
  endtask

  task automatic exp_evt(input logic [3:0] p, input logic d, input logic o);
    evt_t x;
    x.pos = p; x.dir = d; x.ovf = o;
    ev_q.push_back(x);
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      s = snap_q.pop_front();
      n_chk++;
      if (s.cyc < cyc)
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", s.name, s.cyc, cyc);
      else if (pos !== s.pos || (s.chk_dir && dir !== s.dir) || evt_valid !== s.v ||
               evt_ovf !== s.ovf || busy !== s.busy)
        $display("FAIL %s: got pos=%0d dir=%b valid=%b ovf=%b busy=%b, want pos=%0d dir=%b valid=%b ovf=%b busy=%b",
                 s.name, pos, dir, evt_valid, evt_ovf, busy, s.pos, s.dir, s.v, s.ovf, s.busy);
      else
        n_pass++;
    end
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      n_chk++;
      if (ev_q.size() == 0) begin
        $display("FAIL evt_unexpected: got pos=%0d dir=%b ovf=%b, want no event", pos, dir, evt_ovf);
      end else begin
        e = ev_q.pop_front();
        if (pos !== e.pos || dir !== e.dir || evt_ovf !== e.ovf)
          $display("FAIL evt_xfer: got pos=%0d dir=%b ovf=%b, want pos=%0d dir=%b ovf=%b",
                   pos, dir, evt_ovf, e.pos, e.dir, e.ovf);
        else
          n_pass++;
      end
    end
    if (done) begin
      n_chk++;
      if (ev_q.size() != 0)
        $display("FAIL evt_drain: got %0d events never transferred, want 0", ev_q.size());
      else
        n_pass++;
      n_chk++;
      if (snap_q.size() != 0)
        $display("FAIL snap_drain: got %0d unchecked snapshots, want 0", snap_q.size());
      else
        n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int c;
    rst = 1'b0; enc_a_pos = 1'b0; enc_b_lvl = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    exp_snap(cyc, "reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Basic increment step and lockout length
    tick(); t = cyc; enc_a_pos = 1'b1; enc_b_lvl = 1'b0;
    exp_snap(t+1, "basic_t1",   4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_snap(t+4, "basic_busy", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_snap(t+5, "basic_idle", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_evt(4'd1, 1'b1, 1'b0);
    tick(); enc_a_pos = 1'b0;
    repeat (3) tick();
    tick(); evt_ready = 1'b1;
    exp_snap(t+6, "basic_drop", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); evt_ready = 1'b0;

    // Lockout rejects bounce pulses
    tick(); clr = 1'b1; c = cyc;
    exp_snap(c+1, "clr1", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); clr = 1'b0;
    tick(); t = cyc; enc_a_pos = 1'b1; enc_b_lvl = 1'b1;
    exp_snap(t+1, "lock_first", P_DEC0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); enc_a_pos = 1'b0;
    tick(); enc_a_pos = 1'b1;
    tick(); enc_a_pos = 1'b0;
    tick(); enc_a_pos = 1'b1;
    exp_snap(t+5, "lock_ignored", P_DEC0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_evt(P_DEC0, 1'b0, 1'b0);
    tick(); enc_a_pos = 1'b0; evt_ready = 1'b1;
    exp_snap(t+6, "lock_drop", P_DEC0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); evt_ready = 1'b0; enc_b_lvl = 1'b0;

    // Overwrite of an unconsumed event sets the sticky overflow
    tick(); clr = 1'b1; c = cyc;
    exp_snap(c+1, "clr2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); clr = 1'b0;
    tick(); t = cyc; enc_a_pos = 1'b1;
    exp_snap(t+1, "hs_first", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); enc_a_pos = 1'b0;
    repeat (3) tick();
    tick(); enc_a_pos = 1'b1;
    exp_snap(t+6, "ovf_set", 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_evt(4'd2, 1'b1, 1'b1);
    tick(); enc_a_pos = 1'b0;
    tick(); evt_ready = 1'b1;
    exp_snap(t+8, "ovf_valid_drop", 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); evt_ready = 1'b0; clr = 1'b1;
    exp_snap(t+9, "ovf_clr", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); clr = 1'b0;

    // Edge in the same cycle as a transfer: valid stays, no overflow
    tick(); t = cyc; enc_a_pos = 1'b1;
    exp_snap(t+1, "xs_first", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_evt(4'd1, 1'b1, 1'b0);
    tick(); enc_a_pos = 1'b0;
    repeat (3) tick();
    tick(); enc_a_pos = 1'b1; evt_ready = 1'b1;
    exp_snap(t+6, "xs_keep", 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_evt(4'd2, 1'b1, 1'b0);
    tick(); enc_a_pos = 1'b0;
    exp_snap(t+7, "xs_drop", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); evt_ready = 1'b0;
    repeat (3) tick();

    // Count up to the top, then step past it
    tick(); clr = 1'b1;
    tick(); clr = 1'b0; evt_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick(); enc_a_pos = 1'b1; enc_b_lvl = 1'b0;
      exp_evt(4'(i), 1'b1, 1'b0);
      tick(); enc_a_pos = 1'b0;
      repeat (3) tick();
    end
    tick(); t = cyc; enc_a_pos = 1'b1;
    exp_snap(t+1, "bound_inc", P_INC15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_evt(P_INC15, 1'b1, 1'b0);
    tick(); enc_a_pos = 1'b0;
    repeat (3) tick();
    tick(); evt_ready = 1'b0;

    // clr beats a simultaneous edge
    tick(); c = cyc; clr = 1'b1; enc_a_pos = 1'b1; enc_b_lvl = 1'b0;
    exp_snap(c+1, "prio", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); clr = 1'b0; enc_a_pos = 1'b0;
    tick();

    // Asynchronous reset during LOCK, then an edge on release
    tick(); t = cyc; enc_a_pos = 1'b1;
    exp_snap(t+1, "rl_first", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); enc_a_pos = 1'b0;
    tick();
    exp_snap(t+2, "rl_reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1; rst = 1'b0;
    tick();
    tick(); rst = 1'b1; enc_a_pos = 1'b1; c = cyc;
    exp_snap(c+1, "rl_after", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_evt(4'd1, 1'b1, 1'b0);
    tick(); enc_a_pos = 1'b0; evt_ready = 1'b1;
    tick(); evt_ready = 1'b0;
    repeat (5) tick();
    done = 1'b1;
  end

endmodule
